fpu_share_arbiter: RTL and testbench

//  Shares one stb/ack floating-point unit (multiplier or adder, 32-bit IEEE-754) between N requesters.

---
 rtl/fpu_arb_pkg.sv | 32 +++
 rtl/fpu_share_arbiter_picker.sv | 17 +
 rtl/fpu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared state encoding, widths and round-robin helper for the FP-unit sharing arbiter.
package fpu_arb_pkg;

    localparam int FP_W    = 32;
    localparam int MAX_N   = 32;
    localparam int MAX_IDW = $clog2(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_WAIT_Z = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Scanning downwards lets the closest set bit after ptr overwrite any farther one.
    function automatic logic [MAX_IDW-1:0] rr_next(
        input logic [MAX_N-1:0] valid,
        input int               n,
        input int               ptr
    );
        logic [MAX_IDW-1:0] win;
        int idx;
        win = '0;
        for (int k = n; k >= 1; k--) begin
            idx = (ptr + k) % n;
            if (valid[idx[MAX_IDW-1:0]]) win = MAX_IDW'(idx);
        end
        return win;
    endfunction

endpackage

// File: rtl/fpu_share_arbiter_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping; N must not exceed MAX_N.
module rr_picker
    import fpu_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any
);

    assign winner = IDW'(rr_next(MAX_N'(valid), N, int'(ptr)));
    assign any    = |valid;

endmodule

// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter sharing one stb/ack FP unit among N requesters, one operation in flight.
// Define FPU_ARB_STATS_EN to add stat_clr and saturating per-requester grant counters (grant_cnt).
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter  int N     = 4,
`ifdef FPU_ARB_STATS_EN
    parameter  int CNT_W = 16,
`endif
    localparam int IDW   = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FPU_ARB_STATS_EN
    input  logic                stat_clr,
    output logic [N*CNT_W-1:0]  grant_cnt,
`endif
    input  logic [N-1:0]        req_valid,
    input  logic [N*FP_W-1:0]   req_a,
    input  logic [N*FP_W-1:0]   req_b,
    output logic [N-1:0]        req_ready,
    output logic [N-1:0]        rsp_valid,
    output logic [FP_W-1:0]     rsp_data,
    input  logic [N-1:0]        rsp_ack,
    output logic [FP_W-1:0]     fu_a,
    output logic [FP_W-1:0]     fu_b,
    output logic                fu_a_stb,
    input  logic                fu_a_ack,
    output logic                fu_b_stb,
    input  logic                fu_b_ack,
    input  logic [FP_W-1:0]     fu_z,
    input  logic                fu_z_stb,
    output logic                fu_z_ack,
    output logic                busy,
    output logic [IDW-1:0]      grant_id
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic           pick_any;
    logic [FP_W-1:0] a_arr [N];
    logic [FP_W-1:0] b_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*FP_W +: FP_W];
        assign b_arr[i] = req_b[i*FP_W +: FP_W];
    end

    rr_picker #(.N(N)) u_picker (
        .valid  (req_valid),
        .ptr    (ptr),
        .winner (pick),
        .any    (pick_any)
    );

    // The pointer only advances once the response is consumed, so a finished requester drops to last place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= IDW'(N - 1);
            grant_id  <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            fu_a      <= '0;
            fu_b      <= '0;
            fu_a_stb  <= 1'b0;
            fu_b_stb  <= 1'b0;
            fu_z_ack  <= 1'b0;
        end else begin
            req_ready <= '0;
            fu_z_ack  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        fu_a      <= a_arr[pick];
                        fu_b      <= b_arr[pick];
                        req_ready <= N'(1) << pick;
                        grant_id  <= pick;
                        fu_a_stb  <= 1'b1;
                        state     <= S_SEND_A;
                    end
                end
                S_SEND_A: begin
                    if (fu_a_ack) begin
                        fu_a_stb <= 1'b0;
                        fu_b_stb <= 1'b1;
                        state    <= S_SEND_B;
                    end
                end
                S_SEND_B: begin
                    if (fu_b_ack) begin
                        fu_b_stb <= 1'b0;
                        state    <= S_WAIT_Z;
                    end
                end
                S_WAIT_Z: begin
                    if (fu_z_stb) begin
                        rsp_data            <= fu_z;
                        fu_z_ack            <= 1'b1;
                        rsp_valid[grant_id] <= 1'b1;
                        state               <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ack[grant_id]) begin
                        rsp_valid <= '0;
                        ptr       <= grant_id;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

`ifdef FPU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [N];

    // Clear takes priority over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cnt_out
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: transaction-level model checked every cycle, random traffic,
// and directed scenarios with literal expectations (stats checks when FPU_ARB_STATS_EN is defined).
`timescale 1ns/1ps
module tb_fpu_share_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef FPU_ARB_STATS_EN
    localparam int CNT_W = 2;
`endif
    localparam int ST_IDLE = 0, ST_A = 1, ST_B = 2, ST_Z = 3, ST_R = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_a = '0, req_b = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [31:0]     rsp_data;
    logic [N-1:0]    rsp_ack = '0;
    logic [31:0]     fu_a, fu_b;
    logic            fu_a_stb, fu_b_stb, fu_z_ack, busy;
    logic            fu_a_ack = 1'b0, fu_b_ack = 1'b0, fu_z_stb = 1'b0;
    logic [31:0]     fu_z = '0;
    logic [IDW-1:0]  grant_id;
`ifdef FPU_ARB_STATS_EN
    logic            stat_clr = 1'b0;
    logic [N*CNT_W-1:0] grant_cnt;
`endif

    fpu_share_arbiter #(
`ifdef FPU_ARB_STATS_EN
        .CNT_W(CNT_W),
`endif
        .N(N)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef FPU_ARB_STATS_EN
        .stat_clr(stat_clr), .grant_cnt(grant_cnt),
`endif
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
        .fu_a(fu_a), .fu_b(fu_b), .fu_a_stb(fu_a_stb), .fu_a_ack(fu_a_ack),
        .fu_b_stb(fu_b_stb), .fu_b_ack(fu_b_ack), .fu_z(fu_z), .fu_z_stb(fu_z_stb),
        .fu_z_ack(fu_z_ack), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Requesters, FP unit and model state
    logic [N-1:0] pend = '0, waiting = '0;
    logic [31:0]  opa [N], opb [N];
    int ackw [N], ack_tick [N], ready_tick [N];
    int mode = 0, ack_delay = 0, a_delay = 1, b_delay = 1, z_delay = 1;
    bit rand_delays = 1'b0;
    int ca = 0, cb = 0, cz = 0;
    bit u_run = 1'b0;
    logic [31:0] ua = '0, ub = '0;
    int mstage = ST_IDLE, mcur = 0, mlast = N - 1;
    logic [31:0] e_fa = '0, e_fb = '0, e_rd = '0;
    logic [N-1:0] e_rr = '0;
    bit e_zack = 1'b0;
    int order [$];
    int a_hi = 0, rv0 = 0, tick_no = 0;
    logic [N-1:0] t_rv = '0;
    logic [31:0]  t_rd = '0;
    int n_checks = 0, n_pass = 0;

    // Exponent-add multiply: exact for powers of two, good enough as a deterministic unit.
    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
        return a + b - 32'h3f80_0000;
    endfunction

    function automatic int rr_model(input logic [N-1:0] v, input int last);
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int d = (i - last - 1 + 2 * N) % N;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput();
        check("busy",      32'(busy),      32'(mstage != ST_IDLE));
        check("fu_a_stb",  32'(fu_a_stb),  32'(mstage == ST_A));
        check("fu_b_stb",  32'(fu_b_stb),  32'(mstage == ST_B));
        check("rsp_valid", 32'(rsp_valid), (mstage == ST_R) ? (32'd1 << mcur) : 32'd0);
        check("req_ready", 32'(req_ready), 32'(e_rr));
        check("fu_z_ack",  32'(fu_z_ack),  32'(e_zack));
        check("grant_id",  32'(grant_id),  32'(mcur));
        check("fu_a",      fu_a,           e_fa);
        check("fu_b",      fu_b,           e_fb);
        check("rsp_data",  rsp_data,       e_rd);
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_stb"},       32'({fu_a_stb, fu_b_stb, fu_z_ack}), 32'd0);
        check({tag, "_rsp_data"},  rsp_data,       32'd0);
        check({tag, "_fu_a"},      fu_a,           32'd0);
        check({tag, "_fu_b"},      fu_b,           32'd0);
        check({tag, "_grant_id"},  32'(grant_id),  32'd0);
    endtask

    task automatic resetBench();
        pend = '0; waiting = '0;
        for (int i = 0; i < N; i++) ackw[i] = 0;
        ca = 0; cb = 0; cz = 0; u_run = 1'b0;
        req_valid = '0; rsp_ack = '0;
        fu_a_ack = 1'b0; fu_b_ack = 1'b0; fu_z_stb = 1'b0;
        mstage = ST_IDLE; mcur = 0; mlast = N - 1;
        e_fa = '0; e_fb = '0; e_rd = '0; e_rr = '0; e_zack = 1'b0;
    endtask

    task automatic observe();
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                pend[i] = 1'b0; waiting[i] = 1'b1;
                order.push_back(i);
                ready_tick[i] = tick_no;
                if (rand_delays) begin
                    a_delay = $urandom_range(1, 4);
                    b_delay = $urandom_range(1, 4);
                    z_delay = $urandom_range(1, 5);
                end
            end
        end
        if (fu_a_stb) a_hi++;
        if (rsp_valid[0]) rv0++;
        if (rsp_valid != '0) begin t_rv = rsp_valid; t_rd = rsp_data; end
    endtask

    task automatic applyStimulus();
        fu_a_ack = 1'b0;
        fu_b_ack = 1'b0;
        if (fu_a_stb) begin
            ca++;
            if (ca >= a_delay) begin fu_a_ack = 1'b1; ua = fu_a; ca = 0; end
        end
        if (fu_z_stb && fu_z_ack) begin
            fu_z_stb = 1'b0;
            fu_z = $urandom;
        end
        if (fu_b_stb) begin
            cb++;
            if (cb >= b_delay) begin fu_b_ack = 1'b1; ub = fu_b; cb = 0; u_run = 1'b1; cz = 0; end
        end else if (u_run && !fu_z_stb) begin
            cz++;
            if (cz >= z_delay) begin fu_z_stb = 1'b1; fu_z = unit_fn(ua, ub); u_run = 1'b0; end
        end
        rsp_ack = '0;
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) begin
                ackw[i]++;
                if (ackw[i] > ack_delay) begin
                    rsp_ack[i] = 1'b1; ackw[i] = 0; waiting[i] = 1'b0; ack_tick[i] = tick_no;
                    if (mode == 1) ack_delay = $urandom_range(0, 3);
                end
            end else if (mode == 1 && !waiting[i] && $urandom_range(0, 3) == 0) begin
                rsp_ack[i] = 1'b1;
            end
            if (!pend[i] && !waiting[i] && (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0))) begin
                pend[i] = 1'b1; opa[i] = $urandom; opb[i] = $urandom;
            end
        end
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = opa[i];
            req_b[i*32 +: 32] = opb[i];
        end
    endtask

    // Transaction-level expectation for the outputs after the coming rising edge.
    task automatic predict();
        e_rr = '0;
        e_zack = 1'b0;
        case (mstage)
            ST_IDLE: if (req_valid != '0) begin
                mcur = rr_model(req_valid, mlast);
                e_fa = opa[mcur]; e_fb = opb[mcur];
                e_rr = N'(1) << mcur;
                mstage = ST_A;
            end
            ST_A: if (fu_a_ack) mstage = ST_B;
            ST_B: if (fu_b_ack) mstage = ST_Z;
            ST_Z: if (fu_z_stb) begin e_rd = fu_z; e_zack = 1'b1; mstage = ST_R; end
            ST_R: if (rsp_ack[mcur]) begin mlast = mcur; mstage = ST_IDLE; end
            default: mstage = ST_IDLE;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        tick_no++;
        checkOutput();
        observe();
        applyStimulus();
        predict();
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while (k < maxc && !(mstage == ST_IDLE && pend == '0 && waiting == '0)) begin
            tick();
            k++;
        end
        check("drain_in_time", 32'(k < maxc), 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        resetBench();
        @(negedge clk);
        checkZero("reset");
        rst = 1'b1;
    endtask

    initial begin
        int k;
        int exp2 [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            opa[i] = '0; opb[i] = '0; ackw[i] = 0; ack_tick[i] = 0; ready_tick[i] = 0;
        end
        doReset();

        // 1: single multiply 1.0 * 2.0 on requester 0
        mode = 0; a_delay = 1; b_delay = 1; z_delay = 2; ack_delay = 0;
        opa[0] = 32'h3f80_0000; opb[0] = 32'h4000_0000; pend = 4'b0001;
        drain(100);
        check("t1_rsp_valid", 32'(t_rv), 32'h1);
        check("t1_rsp_data",  t_rd,      32'h4000_0000);

        // 2: all four held, immediate acks
        doReset();
        order.delete();
        mode = 2;
        k = 0;
        while (k < 300 && order.size() < 5) begin tick(); k++; end
        mode = 0;
        drain(300);
        check("t2_order_len", 32'(order.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) check("t2_order", 32'(order.size() > i ? order[i] : -1), 32'(exp2[i]));

        // 3: slow A acceptance
        a_delay = 7; a_hi = 0;
        opa[2] = $urandom; opb[2] = $urandom; pend = 4'b0100;
        drain(100);
        check("t3_a_stb_cycles", 32'(a_hi), 32'd7);
        a_delay = 1;

        // 4: response held 10 cycles while requester 1 waits
        ack_delay = 10; rv0 = 0;
        opa[0] = $urandom; opb[0] = $urandom; opa[1] = $urandom; opb[1] = $urandom;
        pend = 4'b0001;
        k = 0;
        while (k < 50 && !waiting[0]) begin tick(); k++; end
        pend[1] = 1'b1;
        drain(300);
        check("t4_rsp_hold", 32'(rv0), 32'd11);
        check("t4_regrant_latency", 32'(ready_tick[1] - ack_tick[0]), 32'd2);
        ack_delay = 0;

        // 5: reset while waiting for the result
        z_delay = 20;
        opa[1] = $urandom; opb[1] = $urandom; pend = 4'b0010;
        k = 0;
        while (k < 50 && mstage != ST_Z) begin tick(); k++; end
        check("t5_reached_wait_z", 32'(mstage), 32'(ST_Z));
        tick(); tick();
        #1 rst = 1'b0;
        resetBench();
        #1 checkZero("t5");
        @(negedge clk);
        rst = 1'b1;
        z_delay = 1; order.delete();
        pend = 4'b1111;
        k = 0;
        while (k < 20 && order.size() == 0) begin tick(); k++; end
        check("t5_restart_grant", 32'(order.size() > 0 ? order[0] : -1), 32'd0);
        drain(300);

        // Random traffic with spurious acks and random unit/requester delays
        mode = 1; rand_delays = 1'b1;
        repeat (1500) tick();
        mode = 0;
        drain(1000);
        rand_delays = 1'b0; a_delay = 1; b_delay = 1; z_delay = 1; ack_delay = 0;

`ifdef FPU_ARB_STATS_EN
        // 6: saturating grant counter and clear
        doReset();
        for (int n = 0; n < 5; n++) begin
            opa[0] = $urandom; opb[0] = $urandom; pend = 4'b0001;
            drain(100);
        end
        check("t6_grant_cnt_sat", 32'(grant_cnt), 32'h03);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("t6_grant_cnt_clr", 32'(grant_cnt), 32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
